// File: rtl/trap_ctrl_if.sv
// trap_ctrl_if: request, CSR-value and CSR-write/redirect signals of trap_ctrl
interface trap_ctrl_if;
  logic        trap_req;
  logic [31:0] trap_cause;
  logic [31:0] trap_epc;
  logic [31:0] trap_tval;
  logic        irq_pending;
  logic [4:0]  irq_code;
  logic [31:0] irq_epc;
  logic        mret_req;
  logic [31:0] mtvec;
  logic [31:0] mepc;
  logic [31:0] mstatus;
  logic        csr_we;
  logic [11:0] csr_waddr;
  logic [31:0] csr_wdata;
  logic        stall;
  logic        flush;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        busy;
  modport master (
    output trap_req, trap_cause, trap_epc, trap_tval, irq_pending, irq_code, irq_epc,
    output mret_req, mtvec, mepc, mstatus,
    input  csr_we, csr_waddr, csr_wdata, stall, flush, redirect_valid, redirect_pc, busy
  );
  modport slave (
    input  trap_req, trap_cause, trap_epc, trap_tval, irq_pending, irq_code, irq_epc,
    input  mret_req, mtvec, mepc, mstatus,
    output csr_we, csr_waddr, csr_wdata, stall, flush, redirect_valid, redirect_pc, busy
  );
endinterface

// File: rtl/trap_ctrl.sv
// trap_ctrl: sequences trap-entry / MRET CSR writes and the PC redirect; define TRAP_VECTORED_EN for vectored interrupt targets
module trap_ctrl (
  input logic        clk,
  input logic        reset,
  trap_ctrl_if.slave bus
);
  typedef enum logic [2:0] {IDLE, W_EPC, W_CAUSE, W_TVAL, W_STATUS, R_STATUS, REDIR} state_t;
  typedef enum logic [1:0] {K_EXC, K_IRQ, K_MRET} kind_t;
  state_t      state_q, state_d;
  kind_t       kind_q, kind_d;
  logic [31:0] cause_q, cause_d;
  logic [31:0] epc_q, epc_d;
  logic [31:0] tval_q, tval_d;
  logic [31:0] status_q, status_d;
  logic        take_exc, take_irq, take_mret, accept, active, wr;
  logic [31:0] st_entry, st_mret, vec_off, target;
  logic        unused_ok;
  // requests only count in IDLE and outside reset; an irq blocked by MIE=0 does not shadow MRET
  assign take_exc  = state_q == IDLE && !reset && bus.trap_req;
  assign take_irq  = state_q == IDLE && !reset && !bus.trap_req && bus.irq_pending && bus.mstatus[3];
  assign take_mret = state_q == IDLE && !reset && !bus.trap_req && !(bus.irq_pending && bus.mstatus[3]) && bus.mret_req;
  assign accept    = take_exc || take_irq || take_mret;
  assign active    = !reset && state_q != IDLE;
  assign wr        = !reset && state_q inside {W_EPC, W_CAUSE, W_TVAL, W_STATUS, R_STATUS};
  assign st_entry  = {status_q[31:13], 2'b11, status_q[10:8], status_q[3], status_q[6:4], 1'b0, status_q[2:0]};
  assign st_mret   = {status_q[31:13], 2'b11, status_q[10:8], 1'b1, status_q[6:4], status_q[7], status_q[2:0]};
`ifdef TRAP_VECTORED_EN
  assign vec_off   = (kind_q == K_IRQ && bus.mtvec[1:0] == 2'b01) ? {25'b0, cause_q[4:0], 2'b00} : 32'h0;
`else
  assign vec_off   = 32'h0;
`endif
  assign target    = {bus.mtvec[31:2], 2'b00} + vec_off;
  assign unused_ok = ^{bus.mtvec[1:0], bus.mepc[1:0], epc_q[1:0], status_q[12:11]};
  // state register and latched trap context
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      kind_q   <= K_EXC;
      cause_q  <= 32'h0;
      epc_q    <= 32'h0;
      tval_q   <= 32'h0;
      status_q <= 32'h0;
    end else begin
      state_q  <= state_d;
      kind_q   <= kind_d;
      cause_q  <= cause_d;
      epc_q    <= epc_d;
      tval_q   <= tval_d;
      status_q <= status_d;
    end
  end
  // next state; context is captured only on acceptance
  always_comb begin
    state_d  = state_q;
    kind_d   = kind_q;
    cause_d  = cause_q;
    epc_d    = epc_q;
    tval_d   = tval_q;
    status_d = status_q;
    case (state_q)
      IDLE: if (accept) begin
        state_d  = take_mret ? R_STATUS : W_EPC;
        kind_d   = take_exc ? K_EXC : take_irq ? K_IRQ : K_MRET;
        cause_d  = take_exc ? bus.trap_cause : take_irq ? {1'b1, 26'b0, bus.irq_code} : 32'h0;
        epc_d    = take_exc ? bus.trap_epc : take_irq ? bus.irq_epc : 32'h0;
        tval_d   = take_exc ? bus.trap_tval : 32'h0;
        status_d = bus.mstatus;
      end
      W_EPC:    state_d = W_CAUSE;
      W_CAUSE:  state_d = W_TVAL;
      W_TVAL:   state_d = W_STATUS;
      W_STATUS: state_d = REDIR;
      R_STATUS: state_d = REDIR;
      default:  state_d = IDLE;
    endcase
  end
  // outputs; reset suppresses everything, including a write due in the reset cycle
  always_comb begin
    bus.busy           = active;
    bus.flush          = accept;
    bus.stall          = accept || active;
    bus.csr_we         = wr;
    bus.csr_waddr      = !wr ? 12'h000 : state_q == W_EPC ? 12'h341 : state_q == W_CAUSE ? 12'h342 :
                         state_q == W_TVAL ? 12'h343 : 12'h300;
    bus.csr_wdata      = !wr ? 32'h0 : state_q == W_EPC ? {epc_q[31:2], 2'b00} : state_q == W_CAUSE ? cause_q :
                         state_q == W_TVAL ? tval_q : state_q == W_STATUS ? st_entry : st_mret;
    bus.redirect_valid = active && state_q == REDIR;
    bus.redirect_pc    = !(active && state_q == REDIR) ? 32'h0 :
                         kind_q == K_MRET ? {bus.mepc[31:2], 2'b00} : target;
  end
endmodule

// File: tb/tb_trap_ctrl.sv
// tb_trap_ctrl: scoreboard bench for trap_ctrl CSR write / redirect sequencing
module tb_trap_ctrl;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int cyc = 0;
  int checks = 0;
  int failures = 0;
  bit mon_en = 1'b0;
  logic [109:0] sb[$];
  logic [109:0] mon_obs, mon_exp;
  trap_ctrl_if bus ();
  trap_ctrl dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  function automatic void exp_w(input logic [11:0] a, input logic [31:0] d, input int c);
    sb.push_back({1'b1, 1'b0, a, d, 32'h0, c});
  endfunction
  function automatic void exp_r(input logic [31:0] pc, input int c);
    sb.push_back({1'b0, 1'b1, 12'h0, 32'h0, pc, c});
  endfunction
  task automatic go(input int t);
    while (cyc < t) begin
      @(posedge clk);
      #1;
    end
  endtask
  always @(negedge clk) if (mon_en) begin
    mon_obs = {bus.csr_we, bus.redirect_valid, bus.csr_waddr, bus.csr_wdata, bus.redirect_pc, cyc};
    checks++;
    if (bus.csr_we !== 1'b0 || bus.redirect_valid !== 1'b0) begin
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL unexpected_output got=%h exp=none", mon_obs);
      end else begin
        mon_exp = sb.pop_front();
        if (mon_obs !== mon_exp) begin
          failures++;
          $display("FAIL sb_event got=%h exp=%h", mon_obs, mon_exp);
        end
      end
    end else if ({bus.csr_waddr, bus.csr_wdata, bus.redirect_pc} !== 76'h0) begin
      failures++;
      $display("FAIL idle_zero cyc=%0d got=%h exp=0", cyc, {bus.csr_waddr, bus.csr_wdata, bus.redirect_pc});
    end
  end
  task automatic test_reset;
    bus.trap_req = 0; bus.trap_cause = 0; bus.trap_epc = 0; bus.trap_tval = 0;
    bus.irq_pending = 0; bus.irq_code = 0; bus.irq_epc = 0; bus.mret_req = 0;
    bus.mtvec = 0; bus.mepc = 0; bus.mstatus = 0;
    reset = 1;
    go(3);
    reset = 0;
    @(negedge clk);
    checks++;
    if ({bus.busy, bus.stall, bus.flush, bus.csr_we, bus.redirect_valid} !== 5'b0) begin
      failures++;
      $display("FAIL reset_ctrl got=%b exp=00000", {bus.busy, bus.stall, bus.flush, bus.csr_we, bus.redirect_valid});
    end
    checks++;
    if ({bus.csr_waddr, bus.csr_wdata, bus.redirect_pc} !== 76'h0) begin
      failures++;
      $display("FAIL reset_data got=%h exp=0", {bus.csr_waddr, bus.csr_wdata, bus.redirect_pc});
    end
    mon_en = 1'b1;
  endtask
  task automatic test_exception;
    int n;
    go(cyc + 1);
    n = cyc;
    bus.trap_req = 1; bus.trap_cause = 2; bus.trap_epc = 32'h100; bus.trap_tval = 32'h73;
    bus.mtvec = 32'h200; bus.mstatus = 32'h8;
    exp_w(12'h341, 32'h100, n + 1);
    exp_w(12'h342, 32'h2, n + 2);
    exp_w(12'h343, 32'h73, n + 3);
    exp_w(12'h300, 32'h1880, n + 4);
    exp_r(32'h200, n + 5);
    @(negedge clk);
    checks++;
    if ({bus.flush, bus.stall, bus.busy} !== 3'b110) begin
      failures++;
      $display("FAIL exc_accept got=%b exp=110", {bus.flush, bus.stall, bus.busy});
    end
    go(n + 1);
    bus.trap_req = 0;
    @(negedge clk);
    checks++;
    if ({bus.flush, bus.stall, bus.busy} !== 3'b011) begin
      failures++;
      $display("FAIL exc_busy got=%b exp=011", {bus.flush, bus.stall, bus.busy});
    end
    go(n + 5);
    @(negedge clk);
    checks++;
    if ({bus.flush, bus.stall, bus.busy} !== 3'b011) begin
      failures++;
      $display("FAIL exc_redir_stall got=%b exp=011", {bus.flush, bus.stall, bus.busy});
    end
    go(n + 6);
    @(negedge clk);
    checks++;
    if ({bus.flush, bus.stall, bus.busy, sb.size() == 0} !== 4'b0001) begin
      failures++;
      $display("FAIL exc_done got=%b pending=%0d exp=000 pending=0", {bus.flush, bus.stall, bus.busy}, sb.size());
    end
  endtask
  task automatic test_mret;
    int n;
    go(cyc + 1);
    n = cyc;
    bus.mret_req = 1; bus.mstatus = 32'h1880; bus.mepc = 32'h104;
    exp_w(12'h300, 32'h1888, n + 1);
    exp_r(32'h104, n + 2);
    @(negedge clk);
    checks++;
    if ({bus.flush, bus.stall, bus.busy} !== 3'b110) begin
      failures++;
      $display("FAIL mret_accept got=%b exp=110", {bus.flush, bus.stall, bus.busy});
    end
    go(n + 1);
    bus.mret_req = 0;
    go(n + 3);
    @(negedge clk);
    checks++;
    if ({bus.flush, bus.stall, bus.busy, sb.size() == 0} !== 4'b0001) begin
      failures++;
      $display("FAIL mret_done got=%b pending=%0d exp=000 pending=0", {bus.flush, bus.stall, bus.busy}, sb.size());
    end
  endtask
  task automatic test_priority;
    int n;
    go(cyc + 1);
    n = cyc;
    bus.trap_req = 1; bus.trap_cause = 32'hB; bus.trap_epc = 32'h400; bus.trap_tval = 0;
    bus.irq_pending = 1; bus.irq_code = 3; bus.irq_epc = 32'h900;
    bus.mret_req = 1; bus.mepc = 32'h104; bus.mstatus = 32'h8; bus.mtvec = 32'h200;
    exp_w(12'h341, 32'h400, n + 1);
    exp_w(12'h342, 32'hB, n + 2);
    exp_w(12'h343, 32'h0, n + 3);
    exp_w(12'h300, 32'h1880, n + 4);
    exp_r(32'h200, n + 5);
    go(n + 1);
    bus.trap_req = 0; bus.irq_pending = 0; bus.mret_req = 0;
    go(n + 6);
    @(negedge clk);
    checks++;
    if ({bus.busy, sb.size() == 0} !== 2'b01) begin
      failures++;
      $display("FAIL prio_done busy=%b pending=%0d exp busy=0 pending=0", bus.busy, sb.size());
    end
  endtask
  task automatic test_irq;
    int n;
    go(cyc + 1);
    bus.mstatus = 0; bus.irq_pending = 1; bus.irq_code = 7; bus.irq_epc = 32'h300; bus.mtvec = 32'h201;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if ({bus.flush, bus.stall, bus.busy} !== 3'b000) begin
        failures++;
        $display("FAIL irq_masked got=%b exp=000", {bus.flush, bus.stall, bus.busy});
      end
      go(cyc + 1);
    end
    n = cyc;
    bus.mstatus = 32'h8;
    exp_w(12'h341, 32'h300, n + 1);
    exp_w(12'h342, 32'h8000_0007, n + 2);
    exp_w(12'h343, 32'h0, n + 3);
    exp_w(12'h300, 32'h1880, n + 4);
`ifdef TRAP_VECTORED_EN
    exp_r(32'h21C, n + 5);
`else
    exp_r(32'h200, n + 5);
`endif
    @(negedge clk);
    checks++;
    if ({bus.flush, bus.stall, bus.busy} !== 3'b110) begin
      failures++;
      $display("FAIL irq_accept got=%b exp=110", {bus.flush, bus.stall, bus.busy});
    end
    go(n + 1);
    bus.irq_pending = 0;
    go(n + 6);
    @(negedge clk);
    checks++;
    if ({bus.busy, sb.size() == 0} !== 2'b01) begin
      failures++;
      $display("FAIL irq_done busy=%b pending=%0d exp busy=0 pending=0", bus.busy, sb.size());
    end
  endtask
  task automatic test_back_to_back;
    int n;
    go(cyc + 1);
    n = cyc;
    bus.trap_req = 1; bus.trap_cause = 4; bus.trap_epc = 32'h106; bus.trap_tval = 32'h55;
    bus.mstatus = 0; bus.mtvec = 32'h203;
    for (int k = 0; k < 2; k++) begin
      exp_w(12'h341, 32'h104, n + 6 * k + 1);
      exp_w(12'h342, 32'h4, n + 6 * k + 2);
      exp_w(12'h343, 32'h55, n + 6 * k + 3);
      exp_w(12'h300, 32'h1800, n + 6 * k + 4);
      exp_r(32'h200, n + 6 * k + 5);
    end
    go(n + 5);
    @(negedge clk);
    checks++;
    if ({bus.flush, bus.stall, bus.busy} !== 3'b011) begin
      failures++;
      $display("FAIL b2b_redir got=%b exp=011", {bus.flush, bus.stall, bus.busy});
    end
    go(n + 6);
    @(negedge clk);
    checks++;
    if ({bus.flush, bus.stall, bus.busy} !== 3'b110) begin
      failures++;
      $display("FAIL b2b_reaccept got=%b exp=110", {bus.flush, bus.stall, bus.busy});
    end
    go(n + 7);
    bus.trap_req = 0;
    go(n + 12);
    @(negedge clk);
    checks++;
    if ({bus.busy, sb.size() == 0} !== 2'b01) begin
      failures++;
      $display("FAIL b2b_done busy=%b pending=%0d exp busy=0 pending=0", bus.busy, sb.size());
    end
  endtask
  task automatic test_reset_mid;
    int n;
    go(cyc + 1);
    n = cyc;
    bus.trap_req = 1; bus.trap_cause = 5; bus.trap_epc = 32'h200; bus.trap_tval = 32'h11;
    bus.mstatus = 32'h8; bus.mtvec = 32'h200;
    exp_w(12'h341, 32'h200, n + 1);
    go(n + 1);
    bus.trap_req = 0;
    go(n + 2);
    reset = 1;
    @(negedge clk);
    checks++;
    if ({bus.csr_we, bus.redirect_valid} !== 2'b00) begin
      failures++;
      $display("FAIL rst_mid_write got=%b exp=00", {bus.csr_we, bus.redirect_valid});
    end
    go(n + 3);
    reset = 0;
    @(negedge clk);
    checks++;
    if ({bus.busy, bus.stall, bus.flush, bus.csr_we, bus.redirect_valid, bus.csr_waddr, bus.csr_wdata, bus.redirect_pc} !== 81'h0) begin
      failures++;
      $display("FAIL rst_mid_outputs got=%h exp=0", {bus.busy, bus.stall, bus.flush, bus.csr_we, bus.redirect_valid, bus.csr_waddr, bus.csr_wdata, bus.redirect_pc});
    end
    go(n + 10);
    @(negedge clk);
    checks++;
    if ({bus.busy, sb.size() == 0} !== 2'b01) begin
      failures++;
      $display("FAIL rst_mid_done busy=%b pending=%0d exp busy=0 pending=0", bus.busy, sb.size());
    end
  endtask
  initial begin
    #200000;
    $display("FAIL timeout cyc=%0d exp=finish", cyc);
    $fatal(1, "timeout");
  end
  initial begin
    test_reset();
    test_exception();
    test_mret();
    test_priority();
    test_irq();
    test_back_to_back();
    test_reset_mid();
    go(cyc + 2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
